flag_branch_unit: RTL and testbench

- Consumer end of the ALU's 3-bit FLAG interface.
- Holds the architectural N/V/Z flag register and applies the per-opcode flag-write rules.
- Evaluates branch conditions for B/BR in the ID stage and produces the branch target.
- Drives a single-cycle ID stall when a flag-writing instruction is still in EX, and the IF flush on a taken branch.

---
 rtl/flag_branch_unit.sv | 198 +++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Consumer end of the ALU FLAG interface. Holds the architectural N/V/Z flag
// register and evaluates B/BR branches in the ID stage.
//
// Flags are written at the clock edge from the instruction leaving EX:
//   - ADD/SUB write N, V and Z.
//   - XOR/SLL/SRA/ROR write Z only.
//   - Every other opcode leaves the flags alone.
//
// A conditional branch in ID that sees a flag writer in EX would otherwise
// read stale flags. In that case the unit raises stall_id for exactly one
// cycle, which holds IF/ID and puts a bubble into EX. It then resolves from
// the updated flags_q in the following cycle.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   ex_flag        - {N,V,Z} produced by the ALU for the EX instruction
//   ex_opcode      - ALU opcode of the EX instruction
//   ex_valid       - EX holds a real instruction
//   pipe_stall     - global freeze; nothing resolves and no state changes
//   id_branch      - ID holds a B or BR
//   id_is_br       - 1: BR (register target), 0: B (PC-relative)
//   id_cond        - 3-bit branch condition code
//   id_pc_plus2    - PC of the branch plus 2
//   id_imm         - signed word offset for B
//   id_rs_data     - register target for BR
//   flags_q        - architectural flags {N,V,Z}
//   stall_id       - hold IF/ID and bubble EX
//   take_branch    - redirect the PC this cycle
//   branch_target  - redirect address; zero whenever take_branch is low
//   flush_if       - squash IF/ID; equal to take_branch
// -----------------------------------------------------------------------------
module flag_branch_unit #(
   parameter int PC_W  = 16,
   parameter int IMM_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       ex_flag,
   input  logic [3:0]       ex_opcode,
   input  logic             ex_valid,
   input  logic             pipe_stall,
   input  logic             id_branch,
   input  logic             id_is_br,
   input  logic [2:0]       id_cond,
   input  logic [PC_W-1:0]  id_pc_plus2,
   input  logic [IMM_W-1:0] id_imm,
   input  logic [PC_W-1:0]  id_rs_data,
   output logic [2:0]       flags_q,
   output logic             stall_id,
   output logic             take_branch,
   output logic [PC_W-1:0]  branch_target,
   output logic             flush_if
);

   // Condition codes
   localparam logic [2:0] COND_NE = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_GT = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_LE = 3'b101;
   localparam logic [2:0] COND_OV = 3'b110;
   localparam logic [2:0] COND_UN = 3'b111;

   // Flag bit positions inside {N,V,Z}
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic {
      RESOLVE = 1'b0,
      WAIT    = 1'b1
   } state_t;

   state_t          state_reg;
   logic [2:0]      flags_reg;

   logic            writes_nvz;
   logic            writes_z;
   logic            fw;
   logic [7:0]      cond_table;
   logic            cond_true;
   logic            hazard;
   logic            resolve_ok;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] b_offset;
   logic [PC_W-1:0] b_target;
   logic [PC_W-1:0] raw_target;

   // -------------------------------------------------------------------------
   // Opcode decode: which flags the EX instruction will write.
   // -------------------------------------------------------------------------
   always_comb begin
      writes_nvz = 1'b0;
      writes_z   = 1'b0;
      case (ex_opcode)
         4'd0, 4'd1:             writes_nvz = 1'b1;   // ADD, SUB
         4'd2, 4'd4, 4'd5, 4'd6: writes_z   = 1'b1;   // XOR, SLL, SRA, ROR
         default: ;
      endcase
   end

   assign fw = ex_valid & (writes_nvz | writes_z);

   // -------------------------------------------------------------------------
   // Condition evaluation on the architectural flags. Every condition is
   // evaluated in parallel and the condition code simply selects one.
   // -------------------------------------------------------------------------
   function automatic logic cond_eval(input logic [2:0] code, input logic [2:0] f);
      logic n, v, z;
      n = f[FLAG_N];
      v = f[FLAG_V];
      z = f[FLAG_Z];
      case (code)
         COND_NE: cond_eval = ~z;
         COND_EQ: cond_eval = z;
         COND_GT: cond_eval = ~z & ~n;
         COND_LT: cond_eval = n;
         COND_GE: cond_eval = z | ~n;
         COND_LE: cond_eval = n | z;
         COND_OV: cond_eval = v;
         default: cond_eval = 1'b1;                   // UN
      endcase
   endfunction

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_cond
         assign cond_table[gi] = cond_eval(3'(gi), flags_reg);
      end
   endgenerate

   assign cond_true = cond_table[id_cond];

   // -------------------------------------------------------------------------
   // Target computation. B offsets are signed word counts, so they are
   // sign-extended and doubled; the sum wraps modulo 2^PC_W. BR passes the
   // register value through unchanged, including bit 0.
   // -------------------------------------------------------------------------
   assign imm_ext    = {{(PC_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
   assign b_offset   = {imm_ext[PC_W-2:0], 1'b0};
   assign b_target   = id_pc_plus2 + b_offset;
   assign raw_target = id_is_br ? id_rs_data : b_target;

   // -------------------------------------------------------------------------
   // Hazard / resolve logic.
   // A conditional branch facing a flag writer in EX stalls once. In WAIT
   // the writer has retired into flags_reg, so the branch resolves without
   // looking at fw again. This is what limits the stall to one cycle.
   // Unconditional branches never depend on flags and never stall.
   // -------------------------------------------------------------------------
   assign hazard = ~rst & ~pipe_stall & (state_reg == RESOLVE) &
                   id_branch & (id_cond != COND_UN) & fw;

   assign resolve_ok = ~rst & ~pipe_stall & ~hazard;

   assign stall_id      = hazard;
   assign take_branch   = resolve_ok & id_branch & cond_true;
   assign flush_if      = take_branch;
   assign branch_target = take_branch ? raw_target : '0;
   assign flags_q       = flags_reg;

   // -------------------------------------------------------------------------
   // State: flag register and the RESOLVE/WAIT controller.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_reg <= 3'b000;
         state_reg <= RESOLVE;
      end else begin
         if (ex_valid && !pipe_stall) begin
            if (writes_nvz) begin
               flags_reg <= ex_flag;
            end else if (writes_z) begin
               flags_reg[FLAG_Z] <= ex_flag[FLAG_Z];
            end
         end

         case (state_reg)
            RESOLVE: begin
               if (hazard) begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               // A frozen pipeline keeps the branch parked in WAIT.
               if (!pipe_stall) begin
                  state_reg <= RESOLVE;
               end
            end
            default: state_reg <= RESOLVE;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_branch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for flag_branch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the flag/branch rules.
// -----------------------------------------------------------------------------
module tb_flag_branch_unit;

   localparam int PC_W  = 16;
   localparam int IMM_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       ex_flag;
   logic [3:0]       ex_opcode;
   logic             ex_valid;
   logic             pipe_stall;
   logic             id_branch;
   logic             id_is_br;
   logic [2:0]       id_cond;
   logic [PC_W-1:0]  id_pc_plus2;
   logic [IMM_W-1:0] id_imm;
   logic [PC_W-1:0]  id_rs_data;
   logic [2:0]       flags_q;
   logic             stall_id;
   logic             take_branch;
   logic [PC_W-1:0]  branch_target;
   logic             flush_if;

   flag_branch_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_flag       (ex_flag),
      .ex_opcode     (ex_opcode),
      .ex_valid      (ex_valid),
      .pipe_stall    (pipe_stall),
      .id_branch     (id_branch),
      .id_is_br      (id_is_br),
      .id_cond       (id_cond),
      .id_pc_plus2   (id_pc_plus2),
      .id_imm        (id_imm),
      .id_rs_data    (id_rs_data),
      .flags_q       (flags_q),
      .stall_id      (stall_id),
      .take_branch   (take_branch),
      .branch_target (branch_target),
      .flush_if      (flush_if)
   );

   always #5 clk = ~clk;

   int vectors_applied = 0;
   int miscompares     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit       m_n, m_v, m_z;
   bit       m_branch_was_held;   // previous cycle stalled a branch for flags
   bit       e_stall, e_take;
   logic [15:0] e_target;

   function automatic bit flag_writer(input logic [3:0] op);
      return (op == 0 || op == 1 || op == 2 || op == 4 || op == 5 || op == 6);
   endfunction

   function automatic bit condition_holds(input logic [2:0] c, input bit n, input bit v, input bit z);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1;
      endcase
   endfunction

   function automatic logic [15:0] target_of(input logic is_br, input logic [15:0] pc,
                                             input logic [8:0] imm, input logic [15:0] rs);
      logic signed [8:0] s;
      int t;
      if (is_br) return rs;
      s = imm;
      t = int'(pc) + 2 * int'(s);
      return t[15:0];
   endfunction

   // Expected outputs for the inputs currently applied
   task automatic model_outputs();
      bit writer_ahead;
      writer_ahead = ex_valid && flag_writer(ex_opcode);
      e_stall = 0;
      e_take  = 0;
      if (!rst && !pipe_stall) begin
         if (!m_branch_was_held && id_branch && id_cond != 3'b111 && writer_ahead)
            e_stall = 1;
         else
            e_take = id_branch && condition_holds(id_cond, m_n, m_v, m_z);
      end
      e_target = e_take ? target_of(id_is_br, id_pc_plus2, id_imm, id_rs_data) : 16'h0000;
   endtask

   // State change at the clock edge
   task automatic model_edge();
      if (rst) begin
         {m_n, m_v, m_z} = 3'b000;
         m_branch_was_held = 0;
      end else if (!pipe_stall) begin
         if (ex_valid && ex_opcode <= 1) {m_n, m_v, m_z} = ex_flag;
         else if (ex_valid && flag_writer(ex_opcode)) m_z = ex_flag[0];
         m_branch_was_held = e_stall;
      end
   endtask

   // One clock: check outputs mid-cycle, advance model at the edge.
   task automatic cycle();
      #1;
      model_outputs();
      check("flags_q", 32'(flags_q), 32'({m_n, m_v, m_z}));
      check("stall_id", 32'(stall_id), 32'(e_stall));
      check("take_branch", 32'(take_branch), 32'(e_take));
      check("flush_if", 32'(flush_if), 32'(e_take));
      check("branch_target", 32'(branch_target), 32'(e_target));
      $display("cyc t=%0t rst=%0b op=%0d v=%0b ps=%0b br=%0b cond=%0d flags=%03b stall=%0b take=%0b tgt=%04h",
               $time, rst, ex_opcode, ex_valid, pipe_stall, id_branch, id_cond,
               flags_q, stall_id, take_branch, branch_target);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_ex(input logic v, input logic [3:0] op, input logic [2:0] f);
      ex_valid = v; ex_opcode = op; ex_flag = f;
   endtask

   task automatic set_id(input logic b, input logic is_br, input logic [2:0] c,
                         input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] rs);
      id_branch = b; id_is_br = is_br; id_cond = c;
      id_pc_plus2 = pc; id_imm = imm; id_rs_data = rs;
   endtask

   task automatic idle();
      set_ex(0, 4'd3, 3'b000);
      set_id(0, 0, 3'd0, 16'h0000, 9'h000, 16'h0000);
      pipe_stall = 0;
   endtask

   initial begin
      rst = 1;
      idle();
      @(negedge clk);
      cycle();
      cycle();
      rst = 0;

      // 1: ADD writes Z, then B EQ taken
      set_ex(1, 4'd0, 3'b001);
      cycle();
      idle();
      #1 check("t1_flags", 32'(flags_q), 32'h1);
      set_id(1, 0, 3'd1, 16'h0100, 9'h004, 16'h0000);
      #1 check("t1_target", 32'(branch_target), 32'h0108);
      check("t1_take", 32'(take_branch), 32'h1);
      cycle();

      // 2: flags 000, XOR in EX, B EQ: one stall then not taken
      rst = 1; idle(); cycle(); rst = 0;
      set_ex(1, 4'd2, 3'b110);
      set_id(1, 0, 3'd1, 16'h0200, 9'h010, 16'h0000);
      #1 check("t2_stall", 32'(stall_id), 32'h1);
      cycle();
      set_ex(0, 4'd3, 3'b000);
      #1 check("t2_flags", 32'(flags_q), 32'h0);
      check("t2_nostall", 32'(stall_id), 32'h0);
      check("t2_take", 32'(take_branch), 32'h0);
      cycle();

      // 3: SUB overflow, B OV: stall then taken; PADDSB does not write
      idle();
      set_ex(1, 4'd1, 3'b010);
      set_id(1, 0, 3'd6, 16'h0300, 9'h1FE, 16'h0000);
      cycle();
      set_ex(0, 4'd3, 3'b000);
      #1 check("t3_take", 32'(take_branch), 32'h1);
      cycle();
      idle();
      set_ex(1, 4'd7, 3'b111);
      cycle();
      #1 check("t3_paddsb", 32'(flags_q), 32'h2);
      cycle();

      // 4: BR UN with flag writer in EX: no stall, taken same cycle
      set_ex(1, 4'd0, 3'b100);
      set_id(1, 1, 3'd7, 16'h0400, 9'h000, 16'hBEEF);
      #1 check("t4_target", 32'(branch_target), 32'hBEEF);
      check("t4_stall", 32'(stall_id), 32'h0);
      cycle();

      // 5: B target wrap and most negative offset
      idle();
      set_id(1, 0, 3'd7, 16'h0000, 9'h1FF, 16'h0000);
      #1 check("t5_wrap", 32'(branch_target), 32'hFFFE);
      cycle();
      set_id(1, 0, 3'd7, 16'h1000, 9'h100, 16'h0000);
      #1 check("t5_neg512", 32'(branch_target), 32'h0E00);
      cycle();

      // 6: stall, frozen WAIT for 3 cycles, release resolves once; then reset in WAIT
      idle();
      set_ex(1, 4'd0, 3'b000);
      set_id(1, 0, 3'd0, 16'h0500, 9'h002, 16'h0000);
      cycle();
      set_ex(0, 4'd3, 3'b000);
      pipe_stall = 1;
      repeat (3) cycle();
      pipe_stall = 0;
      #1 check("t6_release", 32'(take_branch), 32'h1);
      cycle();
      set_ex(1, 4'd1, 3'b111);
      set_id(1, 0, 3'd2, 16'h0600, 9'h002, 16'h0000);
      cycle();
      rst = 1;
      cycle();
      rst = 0;
      set_ex(0, 4'd3, 3'b000);
      #1 check("t6_rst_flags", 32'(flags_q), 32'h0);
      cycle();

      // Random stimulus: branches tend to persist, as they would when held in ID
      for (int i = 0; i < 2500; i++) begin
         rst        = ($urandom_range(0, 63) == 0);
         pipe_stall = ($urandom_range(0, 4) == 0);
         ex_valid   = ($urandom_range(0, 3) != 0);
         ex_opcode  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
         ex_flag    = 3'($urandom);
         if (!id_branch || $urandom_range(0, 2) == 0) begin
            id_branch   = ($urandom_range(0, 1) == 1);
            id_is_br    = ($urandom_range(0, 3) == 0);
            id_cond     = 3'($urandom);
            id_pc_plus2 = 16'($urandom);
            id_imm      = 9'($urandom);
            id_rs_data  = 16'($urandom);
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
